gpio_in_capture: RTL and testbench
==================================

GPIO_IN_CAPTURE -- requirements
Module: gpio_in_capture

Interface
REQ-001 SHALL have parameter DEBOUNCE_TICKS, default 50000, meaning CLOCK_50 cycles between debounce samples (1 ms at 50 MHz).
REQ-002 SHALL have port CLOCK_50  input  1  DE-series 50 MHz clock; sole clock, all state on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port GPIO  input  32  asynchronous external header pins, read only.
REQ-005 SHALL have port SW  input  10  SW[9:8] selects the displayed byte, SW[4:0] selects the counted bit, and SW[7:5] is ignored.
REQ-006 SHALL have port clear  input  1  active-high level; while high, clears sticky flags and the edge counter.
REQ-007 SHALL have port LEDR  output  10  LEDR[7:0] is the debounced selected byte, LEDR[8] is the OR of the sticky rise flags in that byte, and LEDR[9] is the tick indicator.
REQ-008 SHALL have port edge_count  output  16  rising-edge count of the selected debounced bit.

Function
REQ-009 SHALL pass every GPIO bit through a 2-flop synchronizer; no other logic reads raw GPIO.
REQ-010 SHALL have a free-running tick counter 0..DEBOUNCE_TICKS-1 that wraps to 0, with tick high for exactly one cycle when the count equals DEBOUNCE_TICKS-1.
REQ-011 SHALL have each bit shift its synchronized value into a 3-entry sample history on every tick cycle only.
REQ-012 SHALL update the debounced bit, on the cycle after a tick, to the history value when all 3 entries agree, and otherwise hold it.
REQ-013 SHALL give a clean GPIO transition a latency to the debounced output of 2 sync cycles plus 3 ticks plus 1 cycle, and never propagate a glitch shorter than one tick period.
REQ-014 SHALL assert the one-cycle rise pulse of a bit when the debounced value is 1 and its previous-cycle value was 0.
REQ-015 SHALL set the bit's sticky flag on a rise pulse; the flag SHALL hold until clear or reset.
REQ-016 SHALL increment edge_count by 1 on a rise pulse of bit SW[4:0] and saturate at 16'hFFFF with no wrap.
REQ-017 SHALL clear edge_count to 0 on the cycle after the registered SW[4:0] changes value.
REQ-018 SHALL give clear priority over a simultaneous rise pulse: flag and counter are 0 afterwards and that edge is lost.
REQ-019 SHALL select LEDR[7:0] as debounced[8*SW[9:8]+7 : 8*SW[9:8]], combinationally from the registered debounced vector.
REQ-020 SHALL toggle the LEDR[9] register on every tick.
REQ-021 SHALL never drive GPIO.

Reset
REQ-022 SHALL, while reset is high at a clock edge, zero the synchronizers, histories, debounced vector, previous vector, sticky flags, tick counter, edge_count, the LEDR[9] register and the registered bit select.
REQ-023 SHALL result in LEDR = 10'h000 and edge_count = 16'h0000 on the first cycle after reset.
REQ-024 SHALL abandon any debounce in progress when reset is asserted, and SHALL NOT generate a rise pulse on the first cycle after reset.
REQ-025 SHALL give reset priority over clear and tick.

Structure
REQ-026 SHALL place GPIO_WIDTH = 32, the 2-bit byte-select typedef and the 5-bit bit-select typedef in shared package gpio_pkg.
REQ-027 SHALL implement per-bit sync, history and debounce as sub-module gpio_debounce, instantiated GPIO_WIDTH times; the tick counter stays in the parent and is shared.

Verification
REQ-028 SHALL cover this scenario with DEBOUNCE_TICKS = 4: GPIO goes from 0 to 32'h0000_0001 and is held, with SW = 0 -> LEDR[0] rises within 2+12+1 cycles, LEDR[8] = 1 and edge_count = 1.
REQ-029 SHALL cover this scenario: a 3-cycle pulse on GPIO[5] -> debounced bit 5, flag 5 and edge_count stay 0.
REQ-030 SHALL cover this scenario: with SW[4:0] = 3, GPIO[3] toggles cleanly 70000 times -> edge_count saturates at 16'hFFFF.
REQ-031 SHALL cover this scenario: clear asserted in the same cycle as a rise pulse on the counted bit -> edge_count = 0 and flag = 0 on the next cycle.
REQ-032 SHALL cover this scenario: GPIO = 32'hA5C3_0F81 is stable and SW[9:8] steps 0,1,2,3 -> LEDR[7:0] = 81, 0F, C3, A5.
REQ-033 SHALL cover this scenario: reset is pulsed mid-debounce while GPIO = 32'hFFFF_FFFF -> all outputs are 0 the next cycle, then the debounced value rises to all ones after full latency, with edge_count incrementing once.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO input capture block.
//   GPIO_WIDTH : number of header pins captured
//   byte_sel_t : selects one of the four displayed bytes (SW[9:8])
//   bit_sel_t  : selects the bit whose rising edges are counted (SW[4:0])
package gpio_pkg;

  localparam int unsigned GPIO_WIDTH = 32;

  typedef logic [1:0] byte_sel_t;
  typedef logic [4:0] bit_sel_t;

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin synchronizer and debouncer.
//   CLOCK_50  : sole clock, rising edge
//   reset     : synchronous, active-high
//   tick      : shared sample strobe; shifts the synchronized pin into history
//   update    : strobe one cycle after tick; commits an agreeing history
//   gpio_pin  : raw asynchronous pin
//   debounced : filtered pin value
module gpio_debounce (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic tick,
  input  logic update,
  input  logic gpio_pin,
  output logic debounced
);

  logic       sync1;
  logic       sync2;
  logic [2:0] hist;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      hist      <= '0;
      debounced <= 1'b0;
    end else begin
      sync1 <= gpio_pin;
      sync2 <= sync1;
      if (tick)
        hist <= {hist[1:0], sync2};
      // Only a unanimous 3-sample history moves the output; otherwise hold.
      if (update && ((hist == 3'b000) || (hist == 3'b111)))
        debounced <= hist[0];
    end
  end

endmodule

// File: rtl/gpio_in_capture.sv
// GPIO header input capture: per-pin sync + debounce, rise detection,
// sticky rise flags, a saturating edge counter and byte display on LEDR.
//   CLOCK_50   : sole clock, rising edge
//   reset      : synchronous, active-high
//   GPIO       : asynchronous header pins (input only)
//   SW         : [9:8] displayed byte, [4:0] counted bit, [7:5] unused
//   clear      : level; clears sticky flags and edge_count
//   LEDR       : [7:0] debounced byte, [8] OR of its sticky flags, [9] tick toggle
//   edge_count : saturating rising-edge count of the selected bit
module gpio_in_capture
  import gpio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 50000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [GPIO_WIDTH-1:0] GPIO,
  input  logic [9:0]            SW,
  input  logic                  clear,
  output logic [9:0]            LEDR,
  output logic [15:0]           edge_count
);

  localparam int unsigned CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [CNT_W-1:0]      tick_cnt;
  logic                  tick;
  logic                  tick_d;
  logic                  led_toggle;
  logic [GPIO_WIDTH-1:0] debounced;
  logic [GPIO_WIDTH-1:0] deb_prev;
  logic [GPIO_WIDTH-1:0] rise;
  logic [GPIO_WIDTH-1:0] sticky;
  bit_sel_t              bit_sel_q;
  byte_sel_t             byte_sel;
  logic                  unused_sw;

  assign tick      = (tick_cnt == CNT_LAST);
  assign byte_sel  = SW[9:8];
  assign unused_sw = ^SW[7:5];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tick_cnt   <= '0;
      tick_d     <= 1'b0;
      led_toggle <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      tick_d   <= tick;
      if (tick)
        led_toggle <= ~led_toggle;
    end
  end

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_bit
    gpio_debounce u_debounce (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .tick     (tick),
      .update   (tick_d),
      .gpio_pin (GPIO[i]),
      .debounced(debounced[i])
    );
  end

  // deb_prev is zeroed with debounced, so no rise can appear right after reset.
  assign rise = debounced & ~deb_prev;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      deb_prev   <= '0;
      sticky     <= '0;
      bit_sel_q  <= '0;
      edge_count <= '0;
    end else begin
      deb_prev  <= debounced;
      sticky    <= clear ? '0 : (sticky | rise);
      bit_sel_q <= SW[4:0];
      if (clear)
        edge_count <= '0;
      else if (SW[4:0] != bit_sel_q)
        edge_count <= '0;
      else if (rise[bit_sel_q] && (edge_count != '1))
        edge_count <= edge_count + 16'd1;
    end
  end

  always_comb begin
    LEDR      = '0;
    LEDR[7:0] = debounced[{byte_sel, 3'b000} +: 8];
    LEDR[8]   = |sticky[{byte_sel, 3'b000} +: 8];
    LEDR[9]   = led_toggle;
  end

endmodule

// File: tb/tb_gpio_in_capture.sv
module tb_gpio_in_capture;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic [31:0] gpio;
  logic [9:0]  sw;
  logic [9:0]  LEDR;
  logic [15:0] edge_count;

  logic        reset_s, clear_s;
  logic [31:0] gpio_s;
  logic [9:0]  sw_s;
  logic [9:0]  ledr_s;
  logic [15:0] ec_s;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b1;

  always #5 clk = ~clk;

  gpio_in_capture #(.DEBOUNCE_TICKS(T)) dut (
    .CLOCK_50(clk), .reset(reset), .GPIO(gpio), .SW(sw), .clear(clear),
    .LEDR(LEDR), .edge_count(edge_count)
  );

  gpio_in_capture #(.DEBOUNCE_TICKS(1)) dut_sat (
    .CLOCK_50(clk), .reset(reset_s), .GPIO(gpio_s), .SW(sw_s), .clear(clear_s),
    .LEDR(ledr_s), .edge_count(ec_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Sampling instants are every T-th edge since reset; the synchronized
  // view of the pins lags the raw pins by two edges.
  int unsigned   m_k = 0;
  logic [31:0]   m_raw[$];
  logic [31:0]   m_smp[3];
  logic [31:0]   m_deb = '0, m_prev = '0, m_flags = '0;
  logic [15:0]   m_cnt = '0;
  logic [4:0]    m_sel = '0;
  logic          m_led9 = 1'b0;
  bit            m_tick_prev = 1'b0;

  initial foreach (m_smp[i]) m_smp[i] = '0;

  always @(posedge clk) begin
    logic [31:0] seen, rise, agree, nd;
    bit is_tick;
    if (reset) begin
      m_k = 0; m_raw.delete();
      foreach (m_smp[i]) m_smp[i] = '0;
      m_deb = '0; m_prev = '0; m_flags = '0; m_cnt = '0; m_sel = '0;
      m_led9 = 1'b0; m_tick_prev = 1'b0;
    end else begin
      seen    = (m_raw.size() >= 2) ? m_raw[1] : 32'h0;
      is_tick = ((m_k % T) == T - 1);
      rise    = m_deb & ~m_prev;
      m_flags = clear ? 32'h0 : (m_flags | rise);
      if (clear) m_cnt = 0;
      else if (sw[4:0] != m_sel) m_cnt = 0;
      else if (rise[m_sel] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      m_sel = sw[4:0];
      agree = ~(m_smp[0] ^ m_smp[1]) & ~(m_smp[1] ^ m_smp[2]);
      nd    = m_tick_prev ? ((agree & m_smp[0]) | (~agree & m_deb)) : m_deb;
      m_prev = m_deb;
      m_deb  = nd;
      if (is_tick) begin
        m_smp[2] = m_smp[1]; m_smp[1] = m_smp[0]; m_smp[0] = seen;
        m_led9 = ~m_led9;
      end
      m_tick_prev = is_tick;
      m_raw.push_front(gpio);
      if (m_raw.size() > 2) void'(m_raw.pop_back());
      m_k++;
    end
  end

  always @(negedge clk) begin
    int bs;
    if (chk_en) begin
      bs = int'(sw[9:8]);
      check("model_ledr", LEDR, {m_led9, |m_flags[bs*8 +: 8], m_deb[bs*8 +: 8]});
      check("model_edge_count", edge_count, m_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulse_reset;
    reset = 1'b1; cyc(1); reset = 1'b0;
  endtask

  task automatic wait_led0(input int limit, output int n);
    n = 0;
    while (n < limit && LEDR[0] !== 1'b1) begin cyc(1); n++; end
  endtask

  typedef struct {
    logic [31:0] gpio;
    logic [9:0]  sw;
    logic [7:0]  led;
    logic        flag;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n;
    reset = 1'b1; clear = 1'b0; gpio = '0; sw = '0;
    reset_s = 1'b1; clear_s = 1'b0; gpio_s = '0; sw_s = 10'h003;

    tbl[0] = '{32'hA5C3_0F81, 10'b00_000_00000, 8'h81, 1'b1};
    tbl[1] = '{32'hA5C3_0F81, 10'b01_000_00000, 8'h0F, 1'b1};
    tbl[2] = '{32'hA5C3_0F81, 10'b10_111_00000, 8'hC3, 1'b1};
    tbl[3] = '{32'hA5C3_0F81, 10'b11_000_00000, 8'hA5, 1'b1};
    tbl[4] = '{32'h0000_FF00, 10'b00_000_00000, 8'h00, 1'b0};
    tbl[5] = '{32'h0000_FF00, 10'b01_000_00000, 8'hFF, 1'b1};

    cyc(2);
    check("reset_ledr", LEDR, 10'h000);
    check("reset_edge_count", edge_count, 16'h0000);
    reset = 1'b0;
    cyc(1);
    check("post_reset_ledr", LEDR, 10'h000);
    check("post_reset_edge_count", edge_count, 16'h0000);

    // Clean rise on bit 0
    gpio = 32'h0000_0001;
    wait_led0(20, n);
    check("rise_latency_ok", (n <= 15), 1);
    cyc(1);
    check("rise_flag", LEDR[8], 1'b1);
    check("rise_count", edge_count, 16'd1);
    cyc(10);
    check("rise_count_hold", edge_count, 16'd1);

    // Short glitch on bit 5 must not propagate
    pulse_reset();
    sw = 10'h005; cyc(3);
    gpio = 32'h0000_0020; cyc(3);
    gpio = 32'h0;
    repeat (20) begin
      cyc(1);
      check("glitch_bit5", LEDR[5], 1'b0);
    end
    check("glitch_flag", LEDR[8], 1'b0);
    check("glitch_count", edge_count, 16'd0);

    // Clear coincident with a rise pulse on the counted bit
    pulse_reset();
    sw = 10'h000; gpio = 32'h0000_0001;
    wait_led0(20, n);
    check("clr_found_rise", (n <= 15), 1);
    clear = 1'b1; cyc(1); clear = 1'b0;
    check("clr_flag", LEDR[8], 1'b0);
    check("clr_count", edge_count, 16'd0);
    cyc(10);
    check("clr_count_later", edge_count, 16'd0);
    check("clr_bit_still_high", LEDR[0], 1'b1);

    // Reset mid-debounce with all pins high
    pulse_reset();
    gpio = 32'hFFFF_FFFF; sw = 10'h000;
    cyc(7);
    reset = 1'b1; cyc(1); reset = 1'b0;
    check("midreset_ledr", LEDR, 10'h000);
    check("midreset_count", edge_count, 16'd0);
    wait_led0(20, n);
    check("midreset_latency_ok", (n <= 15), 1);
    cyc(2);
    for (int b = 0; b < 4; b++) begin
      sw = {2'(b), 8'h00}; #1;
      check("midreset_byte", LEDR[7:0], 8'hFF);
    end
    check("midreset_count_one", edge_count, 16'd1);
    cyc(1);

    // Byte select table
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || tbl[i].gpio != tbl[i-1].gpio) begin
        pulse_reset();
        gpio = tbl[i].gpio;
        cyc(20);
      end
      sw = tbl[i].sw; #1;
      check("table_led", LEDR[7:0], tbl[i].led);
      check("table_flag", LEDR[8], tbl[i].flag);
      cyc(1);
    end

    // Randomized traffic, checked by the model each cycle
    for (int r = 0; r < 80; r++) begin
      gpio = $urandom;
      if ($urandom_range(0, 5) == 0) sw = 10'($urandom);
      if ($urandom_range(0, 24) == 0) pulse_reset();
      clear = ($urandom_range(0, 9) == 0);
      cyc(1);
      clear = 1'b0;
      cyc($urandom_range(1, 24));
    end

    // Saturation of the edge counter (tick every cycle)
    chk_en = 1'b0;
    cyc(2);
    check("sat_reset_count", ec_s, 16'd0);
    reset_s = 1'b0;
    cyc(2);
    for (int p = 0; p < 100; p++) begin
      gpio_s = 32'h8; cyc(3);
      gpio_s = 32'h0; cyc(3);
    end
    cyc(8);
    check("sat_count_100", ec_s, 16'd100);
    for (int p = 100; p < 70000; p++) begin
      gpio_s = 32'h8; cyc(3);
      gpio_s = 32'h0; cyc(3);
    end
    cyc(8);
    check("sat_count_max", ec_s, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
